// File: rtl/p08_spi_vec_loader.sv
// SPI view-vector loader: receives PX,PY,FX,FY,VX,VY over a mode-0 SPI link and
// commits the double-buffered frame to the trace core on the VBLANK frame tick.
module p08_spi_vec_loader #(
  parameter int unsigned   W          = 16,
  parameter int unsigned   SYNC_DEPTH = 2,
  parameter logic [W-1:0]  DEF_PX     = 16'h0B00,
  parameter logic [W-1:0]  DEF_PY     = 16'h0B00,
  parameter logic [W-1:0]  DEF_FX     = 16'h0000,
  parameter logic [W-1:0]  DEF_FY     = 16'hFC00,
  parameter logic [W-1:0]  DEF_VX     = 16'h0200,
  parameter logic [W-1:0]  DEF_VY     = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_vec_csb,
  input  logic         i_vec_sclk,
  input  logic         i_vec_mosi,
  input  logic         i_frame_tick,
  output logic [W-1:0] o_player_x,
  output logic [W-1:0] o_player_y,
  output logic [W-1:0] o_facing_x,
  output logic [W-1:0] o_facing_y,
  output logic [W-1:0] o_vplane_x,
  output logic [W-1:0] o_vplane_y,
  output logic         o_pending,
  output logic         o_updated,
  output logic         o_frame_err,
  output logic         o_busy
);

  localparam int unsigned FW    = 6 * W;
  localparam int unsigned CNT_W = $clog2(FW + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FW + 1);
  localparam logic [FW-1:0]    DEF_ALL  = {DEF_PX, DEF_PY, DEF_FX, DEF_FY, DEF_VX, DEF_VY};

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  logic [SYNC_DEPTH-1:0] csb_sync_q, sclk_sync_q, mosi_sync_q;
  logic                  sclk_prev_q;
  logic                  csb_s, sclk_s, mosi_s, sclk_rise;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]     shift_q, shift_d;
  logic [FW-1:0]     buf_q, buf_d;
  logic [FW-1:0]     out_q, out_d;
  logic              pend_q, pend_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic              done_c;

  // Pin synchronisers; csb idles high so reset mid-transfer shows a fresh falling edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      csb_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[SYNC_DEPTH-2:0], i_vec_csb};
      sclk_sync_q <= {sclk_sync_q[SYNC_DEPTH-2:0], i_vec_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_DEPTH-2:0], i_vec_mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign csb_s     = csb_sync_q[SYNC_DEPTH-1];
  assign sclk_s    = sclk_sync_q[SYNC_DEPTH-1];
  assign mosi_s    = mosi_sync_q[SYNC_DEPTH-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      out_q   <= DEF_ALL;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  // Transfer FSM plus commit; a tick always commits the buffer as it stood before this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    out_d   = out_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    done_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!csb_s) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (csb_s) begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_FULL) begin
            done_c = 1'b1;
            buf_d  = shift_q;
          end else if (cnt_q != '0) begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FW-2:0], mosi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_frame_tick && pend_q) begin
      out_d = buf_q;
      upd_d = 1'b1;
    end
    pend_d = done_c | (pend_q & ~i_frame_tick);
  end

  assign o_player_x  = out_q[6*W-1 -: W];
  assign o_player_y  = out_q[5*W-1 -: W];
  assign o_facing_x  = out_q[4*W-1 -: W];
  assign o_facing_y  = out_q[3*W-1 -: W];
  assign o_vplane_x  = out_q[2*W-1 -: W];
  assign o_vplane_y  = out_q[W-1 -: W];
  assign o_pending   = pend_q;
  assign o_updated   = upd_q;
  assign o_frame_err = err_q;
  assign o_busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_p08_spi_vec_loader.sv
// Randomised bench for p08_spi_vec_loader against a transaction-level model of
// frame buffering, commit-on-tick and bit-count error rules.
module tb_p08_spi_vec_loader;

  localparam int unsigned W    = 16;
  localparam int unsigned SD   = 2;
  localparam int unsigned HALF = SD + 2;
  localparam logic [95:0] DEF_ALL = {16'h0B00, 16'h0B00, 16'h0000, 16'hFC00, 16'h0200, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic csb = 1'b1, sclk = 1'b0, mosi = 1'b0, tick = 1'b0;
  logic [W-1:0] px, py, fx, fy, vx, vy;
  logic pending, updated, frame_err, busy;

  p08_spi_vec_loader dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_vec_csb(csb), .i_vec_sclk(sclk),
    .i_vec_mosi(mosi), .i_frame_tick(tick),
    .o_player_x(px), .o_player_y(py), .o_facing_x(fx), .o_facing_y(fy),
    .o_vplane_x(vx), .o_vplane_y(vy),
    .o_pending(pending), .o_updated(updated), .o_frame_err(frame_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int upd_cnt = 0;

  // Pulse-width-aware counters: a one-cycle pulse is seen on exactly one falling edge.
  always @(negedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (updated)   upd_cnt <= upd_cnt + 1;
  end

  // Reference state
  logic [95:0] m_out = DEF_ALL;
  logic [95:0] m_buf = '0;
  bit          m_pend = 1'b0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return {px, py, fx, fy, vx, vy};
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = v[127-i];
      clks(HALF);
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_out"}, outs(), m_out);
    chk({tag, "_pend"}, 96'(pending), 96'(m_pend));
  endtask

  // One full transfer of n bits; with_tick lands a frame tick on the csb-rise action cycle.
  task automatic xfer(input string tag, input logic [127:0] v, input int n, input bit with_tick);
    int e0;
    int u0;
    bit exp_upd;
    csb = 1'b0;
    clks(HALF);
    chk({tag, "_busy"}, 96'(busy), 96'd1);
    shift_bits(v, n);
    clks(HALF);
    e0 = err_cnt;
    u0 = upd_cnt;
    csb = 1'b1;
    exp_upd = 1'b0;
    if (with_tick) begin
      clks(SD);
      tick = 1'b1;
      clks(1);
      tick = 1'b0;
      exp_upd = m_pend;
      if (m_pend) begin
        m_out  = m_buf;
        m_pend = 1'b0;
      end
      chk({tag, "_upd"}, 96'(updated), 96'(exp_upd));
      clks(2);
    end else begin
      clks(SD + 2);
    end
    if (n == 96) begin
      m_buf  = v[127:32];
      m_pend = 1'b1;
    end
    check_state(tag);
    chk({tag, "_errn"}, 96'(err_cnt - e0), (n == 0 || n == 96) ? 96'd0 : 96'd1);
    chk({tag, "_updn"}, 96'(upd_cnt - u0), 96'(exp_upd));
    chk({tag, "_idle"}, 96'(busy), 96'd0);
  endtask

  task automatic do_tick(input string tag);
    int u0;
    bit exp_upd;
    u0 = upd_cnt;
    tick = 1'b1;
    clks(1);
    tick = 1'b0;
    exp_upd = m_pend;
    if (m_pend) begin
      m_out  = m_buf;
      m_pend = 1'b0;
    end
    chk({tag, "_upd"}, 96'(updated), 96'(exp_upd));
    check_state(tag);
    clks(2);
    chk({tag, "_updn"}, 96'(upd_cnt - u0), 96'(exp_upd));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] v;
    int e0;
    int n;

    clks(3);
    rst_n = 1'b1;
    clks(2);
    // 1: reset state
    check_state("reset");
    chk("reset_flags", {92'd0, updated, frame_err, busy, pending}, 96'd0);

    // 2: directed frame, then commit
    v = {16'h1234, 16'h5678, 16'h0100, 16'hFF00, 16'h0080, 16'h0040, 32'h0};
    xfer("frame", v, 96, 1'b0);
    do_tick("commit");
    chk("commit_vals", outs(), v[127:32]);

    // 3: short and long frames
    xfer("short95", rnd128(), 95, 1'b0);
    xfer("long97", rnd128(), 97, 1'b0);
    xfer("empty0", rnd128(), 0, 1'b0);

    // 4: overwrite before tick, then coincident tick + completion
    xfer("fa", rnd128(), 96, 1'b0);
    xfer("fb", rnd128(), 96, 1'b0);
    do_tick("tick_b");
    xfer("fb2", rnd128(), 96, 1'b0);
    xfer("fc_tick", rnd128(), 96, 1'b1);
    chk("fc_pend", 96'(pending), 96'd1);
    do_tick("tick_c");

    // 5: reset during a transfer, remainder flagged as error
    v = rnd128();
    csb = 1'b0;
    clks(HALF);
    shift_bits(v, 40);
    rst_n = 1'b0;
    clks(2);
    m_out  = DEF_ALL;
    m_pend = 1'b0;
    check_state("rst_mid");
    rst_n = 1'b1;
    clks(HALF);
    e0 = err_cnt;
    shift_bits(v << 40, 56);
    clks(HALF);
    csb = 1'b1;
    clks(SD + 2);
    chk("rst_err", 96'(err_cnt - e0), 96'd1);
    check_state("rst_after");
    xfer("rst_full", rnd128(), 96, 1'b0);
    do_tick("rst_tick");

    // 6: sclk activity with csb high is ignored
    for (int i = 0; i < 20; i++) begin
      mosi = $urandom_range(0, 1);
      clks(HALF);
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
    end
    clks(SD + 2);
    check_state("idle_sclk");
    do_tick("idle_tick");

    // Random mix of lengths and ticks
    for (int i = 0; i < 10; i++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 100)) : 96;
      xfer("rnd", rnd128(), n, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_tick("rnd_tick");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
